// File: rtl/fifo_pkg.sv
// Definitions shared between the sync FIFO and its stream reader.
// Occupancy encoding for the reader's two-entry skid buffer and the default word width.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 32;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer (main + skid) with valid/ready output handshake.
// in_valid must only be asserted when occ != OCC_FULL; the caller does that gating.
import fifo_pkg::*;

module stream_skid_buf #(
    parameter int unsigned WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output occ_e             occ
);

    logic [WIDTH-1:0] skid_q;
    logic             acc;

    assign acc = out_valid && out_ready;

    // out_data is the main entry; skid only holds a word while occ is FULL
    always_ff @(posedge clk) begin
        if (reset) begin
            occ       <= OCC_EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_q    <= '0;
        end else begin
            unique case (occ)
                OCC_EMPTY: begin
                    if (in_valid) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        occ       <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_valid && acc) begin
                        out_data <= in_data;
                    end else if (in_valid) begin
                        skid_q <= in_data;
                        occ    <= OCC_FULL;
                    end else if (acc) begin
                        out_valid <= 1'b0;
                        occ       <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (acc) begin
                        out_data <= skid_q;
                        occ      <= OCC_ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    occ       <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops the sync FIFO into a skid buffer and presents a framed valid/ready stream.
// Optional macro STREAM_PARITY_EN adds m_parity, the XOR reduction of the presented word.
import fifo_pkg::*;

module fifo_stream_reader #(
    parameter int unsigned WIDTH     = FIFO_WIDTH,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] data_out,
    output logic             r_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] frame_count,
    output logic             busy
`ifdef STREAM_PARITY_EN
    ,
    output logic             m_parity
`endif
);

    localparam int unsigned WC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [WC_W-1:0] LAST_IDX = WC_W'(FRAME_LEN - 1);

`ifdef STREAM_PARITY_EN
    localparam int unsigned BUF_W = WIDTH + 1;
`else
    localparam int unsigned BUF_W = WIDTH;
`endif

    occ_e             occ;
    logic [BUF_W-1:0] buf_in;
    logic [BUF_W-1:0] buf_out;
    logic [WC_W-1:0]  word_cnt;
    logic             acc;

    // Pop gating depends only on the FIFO flag and registered occupancy, never on m_ready
    assign r_ready = !reset && !fifo_empty && (occ != OCC_FULL);
    assign acc     = m_valid && m_ready;
    assign busy    = (occ != OCC_EMPTY);
    assign m_last  = m_valid && (word_cnt == LAST_IDX);

`ifdef STREAM_PARITY_EN
    assign buf_in   = {^data_out, data_out};
    assign m_parity = buf_out[WIDTH];
`else
    assign buf_in   = data_out;
`endif
    assign m_data = buf_out[WIDTH-1:0];

    stream_skid_buf #(
        .WIDTH (BUF_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (r_ready),
        .in_data   (buf_in),
        .out_ready (m_ready),
        .out_valid (m_valid),
        .out_data  (buf_out),
        .occ       (occ)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt    <= '0;
            frame_count <= '0;
        end else if (acc) begin
            if (word_cnt == LAST_IDX) begin
                word_cnt    <= '0;
                frame_count <= frame_count + 1'b1;
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: FIFO model, scoreboard and vector table.
// Build with STREAM_PARITY_EN defined to also exercise m_parity.
module tb_fifo_stream_reader;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned CNT_W     = 16;

    logic             clk;
    logic             reset;
    logic             fifo_empty;
    logic [WIDTH-1:0] data_out;
    logic             r_ready;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic [CNT_W-1:0] frame_count;
    logic             busy;
`ifdef STREAM_PARITY_EN
    logic             m_parity;
`endif

    fifo_stream_reader #(
        .WIDTH     (WIDTH),
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .data_out    (data_out),
        .r_ready     (r_ready),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .frame_count (frame_count),
        .busy        (busy)
`ifdef STREAM_PARITY_EN
        ,
        .m_parity    (m_parity)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    typedef struct {
        logic             m_ready;
        logic             r_ready;
        logic             valid;
        logic [WIDTH-1:0] data;
        logic             last;
        logic             busy;
    } vec_t;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] fq[$];
    exp_t             sb[$];
    int               widx = 0;
    logic [CNT_W-1:0] fc_exp = '0;
    vec_t             tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        data_out   = fifo_empty ? '0 : fq[0];
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        fq.push_back(w);
        drive_fifo();
    endtask

    // One clock: sample handshakes before the edge, update FIFO model after it
    task automatic step();
        logic pop_now;
        logic acc_now;
        exp_t e;
        #4;
        pop_now = r_ready && !fifo_empty && !reset;
        acc_now = m_valid && m_ready && !reset;
        if (acc_now) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got word %0h, expected no word", m_data);
            end else begin
                e = sb.pop_front();
                check("sb_data", m_data, e.data);
                check("sb_last", 32'(m_last), 32'(e.last));
                if (e.last) fc_exp = fc_exp + 1'b1;
            end
        end
        if (pop_now) begin
            sb.push_back({data_out, (widx == FRAME_LEN - 1)});
            widx = (widx == FRAME_LEN - 1) ? 0 : widx + 1;
        end
        @(posedge clk);
        #1;
        if (pop_now) void'(fq.pop_front());
        if (reset) begin
            sb.delete();
            widx   = 0;
            fc_exp = '0;
        end
        drive_fifo();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gaps;
        int seen_valid;

        // m_ready, r_ready, m_valid, m_data, m_last, busy
        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 32'd2, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};

        reset   = 1'b1;
        m_ready = 1'b0;
        drive_fifo();
        @(posedge clk);
        #1;

        // Reset then idle with an empty FIFO
        do_reset();
        check("rst_m_data", m_data, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_r_ready", 32'(r_ready), 32'd0);
            check("idle_m_valid", 32'(m_valid), 32'd0);
            check("idle_frame_count", 32'(frame_count), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // Preloaded frame at full rate
        for (int i = 0; i < 4; i++) push(32'(i));
        m_ready = 1'b1;
        step();
        check("lat_m_valid", 32'(m_valid), 32'd1);
        check("lat_m_data", m_data, 32'd0);
        for (int i = 0; i < 6; i++) step();
        check("frame_count_1", 32'(frame_count), 32'(fc_exp));
        check("frame_count_1_abs", 32'(frame_count), 32'd1);
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_sb", 32'(sb.size()), 32'd0);

        // Back-pressure with three words available
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) fq.push_back(32'(i));
        do_reset();
        drive_fifo();
        for (int i = 0; i < 8; i++) begin
            m_ready = tbl[i].m_ready;
            #3;
            check("bp_r_ready", 32'(r_ready), 32'(tbl[i].r_ready));
            check("bp_m_valid", 32'(m_valid), 32'(tbl[i].valid));
            if (tbl[i].valid) check("bp_m_data", m_data, tbl[i].data);
            check("bp_m_last", 32'(m_last), 32'(tbl[i].last));
            check("bp_busy", 32'(busy), 32'(tbl[i].busy));
            if (i == 3) check("bp_two_pops", 32'(fq.size()), 32'd1);
            step();
        end
        check("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Stall mid-frame
        m_ready = 1'b1;
        do_reset();
        push(32'd0);
        push(32'd1);
        gaps       = 0;
        seen_valid = 0;
        for (int i = 0; i < 7; i++) begin
            #3;
            if (m_valid) seen_valid = 1;
            else if (seen_valid != 0) gaps++;
            step();
        end
        check("stall_gap_seen", 32'(gaps > 0), 32'd1);
        check("stall_frame_count", 32'(frame_count), 32'd0);
        push(32'd2);
        push(32'd3);
        for (int i = 0; i < 5; i++) step();
        check("stall_frame_done", 32'(frame_count), 32'd1);
        check("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Reset while the skid buffer is full
        m_ready = 1'b0;
        do_reset();
        push(32'd5);
        push(32'd6);
        push(32'd7);
        for (int i = 0; i < 3; i++) step();
        #3;
        check("full_busy", 32'(busy), 32'd1);
        check("full_r_ready", 32'(r_ready), 32'd0);
        check("full_m_data", m_data, 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_no_pop", 32'(fq.size()), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        m_ready = 1'b1;
        step();
        check("post_rst_m_data", m_data, 32'd7);
        check("post_rst_m_last", 32'(m_last), 32'd0);
        push(32'd8);
        push(32'd9);
        push(32'd10);
        for (int i = 0; i < 5; i++) step();
        check("post_rst_frame_count", 32'(frame_count), 32'd1);
        check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

`ifdef STREAM_PARITY_EN
        m_ready = 1'b0;
        do_reset();
        push(32'h0000_0003);
        step();
        check("parity_3", 32'(m_parity), 32'd0);
        m_ready = 1'b1;
        push(32'h0000_0007);
        step();
        check("parity_7_data", m_data, 32'h0000_0007);
        check("parity_7", 32'(m_parity), 32'd1);
        step();
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
